// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit pipelined core: opcodes, ALU codes,
// instruction field positions and the EX-stage control bundle.
package cpu16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    // Major opcodes, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;

    // ALU operation codes driven on alu_control
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b110;

    // Instruction field positions
    localparam int OP_HI     = 15;
    localparam int OP_LO     = 12;
    localparam int RS_HI     = 11;
    localparam int RS_LO     = 9;
    localparam int RT_HI     = 8;
    localparam int RT_LO     = 6;
    localparam int RD_HI     = 5;
    localparam int RD_LO     = 3;
    localparam int FN_HI     = 2;
    localparam int FN_LO     = 0;
    localparam int IMM6_HI   = 5;
    localparam int IMM8_HI   = 7;
    localparam int LUI_RT_HI = 11;
    localparam int LUI_RT_LO = 9;

    // Control bundle held in the EX slot; all-zero is a bubble.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             illegal;
        logic [2:0]       alu_control;
        logic             in2_from_rt;  // alu_in2 takes forwarded rt, else immediate
    } ex_ctrl_t;

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Three-way priority operand forward select: MEM result, then WB data,
// then the value captured in the pipeline register. r0 is never forwarded.
module fwd_mux
    import cpu16_pkg::*;
(
    input  logic [REG_W-1:0]  src_idx_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic              mem_wr_i,
    input  logic [REG_W-1:0]  mem_rd_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic              wb_wr_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] fwd_val_o
);

    // Pick the youngest in-flight producer of src_idx_i
    always_comb begin
        if (mem_wr_i && (mem_rd_i != '0) && (mem_rd_i == src_idx_i)) begin
            fwd_val_o = mem_result_i;
        end else if (wb_wr_i && (wb_rd_i != '0) && (wb_rd_i == src_idx_i)) begin
            fwd_val_o = wb_data_i;
        end else begin
            fwd_val_o = reg_val_i;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register and operand issue: decodes the ID instruction,
// captures operands (with WB bypass), forwards into the ALU operands in EX,
// and generates the load-use stall and flush bubbles for the EX slot.
module ex_issue_stage
    import cpu16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [15:0]       id_instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    input  logic              mem_wr,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wr,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_control,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_illegal
);

    logic [3:0]        id_op;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [2:0]        id_funct;
    logic [DATA_W-1:0] rs_cap, rt_cap;
    logic              id_uses_rt;

    ex_ctrl_t          ex_d, ex_q;
    logic [REG_W-1:0]  rs_idx_d, rs_idx_q, rt_idx_d, rt_idx_q;
    logic [DATA_W-1:0] rs_val_d, rs_val_q, rt_val_d, rt_val_q, imm_d, imm_q;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    assign id_op    = id_instr[OP_HI:OP_LO];
    assign id_rs    = id_instr[RS_HI:RS_LO];
    assign id_rt    = id_instr[RT_HI:RT_LO];
    assign id_rd    = id_instr[RD_HI:RD_LO];
    assign id_funct = id_instr[FN_HI:FN_LO];

    // A WB write landing this cycle is not yet visible in the register file
    assign rs_cap = (wb_wr && (wb_rd != '0) && (wb_rd == id_rs)) ? wb_data : rs_data;
    assign rt_cap = (wb_wr && (wb_rd != '0) && (wb_rd == id_rt)) ? wb_data : rt_data;

    assign id_uses_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);

    // Load-use hazard: the loaded value is not available until after MEM
    assign id_stall = !flush && ex_q.valid && ex_q.mem_read && id_valid && (ex_q.rd != '0)
                      && ((ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt)));

    // Decode the ID instruction into the next EX contents
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        ex_d             = '0;
        ex_d.valid       = 1'b1;
        rs_idx_d         = id_rs;
        rs_val_d         = rs_cap;
        rt_idx_d         = '0;
        rt_val_d         = '0;
        imm_d            = sext6(id_instr[IMM6_HI:0]);
        unique case (id_op)
            OP_RTYPE: begin
                if (id_funct inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT}) begin
                    ex_d.alu_control = id_funct;
                    ex_d.in2_from_rt = 1'b1;
                    ex_d.rd          = id_rd;
                    rt_idx_d         = id_rt;
                    rt_val_d         = rt_cap;
                end else begin
                    ex_d.illegal = 1'b1;
                end
            end
            OP_ADDI: begin
                ex_d.alu_control = ALU_ADD;
                ex_d.rd          = id_rt;
            end
            OP_LW: begin
                ex_d.alu_control = ALU_ADD;
                ex_d.mem_read    = 1'b1;
                ex_d.rd          = id_rt;
            end
            OP_SW: begin
                ex_d.alu_control = ALU_ADD;
                ex_d.mem_write   = 1'b1;
                rt_idx_d         = id_rt;
                rt_val_d         = rt_cap;
            end
            OP_BEQ: begin
                ex_d.alu_control = ALU_SUB;
                ex_d.branch      = 1'b1;
                ex_d.in2_from_rt = 1'b1;
                rt_idx_d         = id_rt;
                rt_val_d         = rt_cap;
            end
            OP_LUI: begin
                ex_d.alu_control = ALU_LUI;
                ex_d.rd          = id_instr[LUI_RT_HI:LUI_RT_LO];
                rs_idx_d         = '0;  // r0 index keeps in1 at zero, never forwarded
                rs_val_d         = '0;
                imm_d            = {{(DATA_W-8){1'b0}}, id_instr[IMM8_HI:0]};
            end
            default: ex_d.illegal = 1'b1;
        endcase
        if (ex_d.illegal) begin
            // Undefined instruction occupies EX as a flagged bubble
            ex_d         = '0;
            ex_d.valid   = 1'b1;
            ex_d.illegal = 1'b1;
            rs_idx_d     = '0;
            rs_val_d     = '0;
            imm_d        = '0;
        end
        ex_d.reg_write = (ex_d.rd != '0);
    end

    // ID/EX register: reset > flush > stall bubble > capture
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            ex_q     <= '0;
            rs_idx_q <= '0;
            rt_idx_q <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
        end else if (flush || id_stall || !id_valid) begin
            ex_q     <= '0;
            rs_idx_q <= '0;
            rt_idx_q <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
        end else begin
            ex_q     <= ex_d;
            rs_idx_q <= rs_idx_d;
            rt_idx_q <= rt_idx_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
        end
    end

    fwd_mux u_fwd_rs (
        .src_idx_i    (rs_idx_q),
        .reg_val_i    (rs_val_q),
        .mem_wr_i     (mem_wr),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .wb_wr_i      (wb_wr),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .fwd_val_o    (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .src_idx_i    (rt_idx_q),
        .reg_val_i    (rt_val_q),
        .mem_wr_i     (mem_wr),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .wb_wr_i      (wb_wr),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .fwd_val_o    (rt_fwd)
    );

    assign alu_in1       = rs_fwd;
    assign alu_in2       = ex_q.in2_from_rt ? rt_fwd : imm_q;
    assign ex_store_data = rt_fwd;
    assign alu_control   = ex_q.alu_control;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline register and operand issue unit for the 16-bit pipelined core. Decodes the instruction leaving ID into the 3-bit ALU operation code and control bits. Selects and forwards the two 16-bit ALU operands, then registers everything into the EX stage. It is the producing end of the ALU's `in1`/`in2`/`alu_control` interface, and it also owns load-use stall generation and flush handling for the EX slot.

## Interface
- No parameters. Data width 16, register index width 3.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_instr` in 16: instruction in ID.
- `rs_data`, `rt_data` in 16 each: register-file read data for `id_instr`.
- `flush` in 1: branch taken; kill ID and EX contents.
- `mem_wr`, `mem_rd`, `mem_result` in 1/3/16: MEM-stage write-back intent, destination, and ALU result.
- `wb_wr`, `wb_rd`, `wb_data` in 1/3/16: WB-stage register write.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `alu_in1`, `alu_in2` out 16 each: ALU operands, forwarded.
- `alu_control` out 3: ALU operation.
- `ex_valid`, `ex_rd`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` out 1/3/1/1/1/1: EX-stage control.
- `ex_store_data` out 16: forwarded rt value for SW.
- `ex_illegal` out 1: EX holds an undefined opcode (1-cycle flag).

## Operation
- Instruction formats:
  - op[15:12]; rs[11:9]; rt[8:6]; rd[5:3]; funct[2:0]; imm6[5:0] sign-extended.
  - LUI only: rt[11:9], imm8[7:0] zero-extended.
- Decode:
  - op 0000 R-type: funct 000 add, 001 sub, 010 and, 011 or, 100 slt → alu_control = funct. Other funct values are illegal. Destination rd.
  - 0001 ADDI: 000, in2 = imm, dest rt.
  - 0010 LW: 000, mem_read, dest rt.
  - 0011 SW: 000, mem_write, no reg write.
  - 0100 BEQ: 001, branch, no reg write.
  - 0101 LUI: 110, in1 = 0, in2 = imm8, dest rt.
  - Any other op: illegal. Registered as bubble controls (reg_write/mem/branch = 0, alu_control 000) with `ex_illegal` = 1 and `ex_valid` = 1.
- Writes to r0 are suppressed: `ex_reg_write` = 0 when the destination is 0.
- ID capture bypass: if `wb_wr` and `wb_rd` ≠ 0 and `wb_rd` equals the rs (or rt) field, capture `wb_data` instead of the register-file data.
- EX forwarding (combinational on registered operands):
  - MEM source: `mem_wr`, `mem_rd` ≠ 0, `mem_rd` = ex_rs.
  - WB source: same conditions on the wb signals.
  - Otherwise the registered value is used.
  - MEM has priority over WB. Register 0 is never forwarded.
  - The forwarded rt value drives `ex_store_data`, and drives `alu_in2` for R-type and BEQ.
- Load-use stall: `id_stall` = `ex_valid` & `ex_mem_read` & `id_valid` & (`ex_rd` = id rs, or, for R-type/SW/BEQ, `ex_rd` = id rt), with `ex_rd` ≠ 0. On stall, a bubble is inserted into EX.
- Priority at the clock edge: `rst` > `flush` > stall > capture.

## Timing
- Reset value of every registered output is 0: `ex_valid`, `ex_rd`, all control bits, `alu_control` 000, stored operands, `ex_illegal`. Combinational outputs follow, so `alu_in1`/`alu_in2` = 0 after reset.
- Latency: one cycle. An instruction valid in ID at edge N appears on the EX outputs after edge N.
- Stall: `id_stall` is combinational, asserted in the same cycle as the hazard, and lasts exactly one cycle per load-use pair. On the next edge EX takes a bubble (`ex_valid` = 0). The instruction is re-presented the following cycle and captured.
- Flush: at the next edge EX takes a bubble regardless of `id_valid` or stall. `id_stall` is forced to 0 while `flush` = 1.
- `id_valid` = 0: EX takes a bubble.
- A bubble means all control outputs are 0. The operand registers also clear to 0.
- `rst` asserted mid-stream: all EX state is cleared at that edge. Any pending stall is dropped.

## Structure
- Shared package `cpu16_pkg`:
  - opcode constants and `ALU_ADD/SUB/AND/OR/SLT/LUI` codes (000/001/010/011/100/110);
  - field-position constants;
  - the EX control-bundle struct.
- One sub-module, `fwd_mux`: 3-way priority forward select, instantiated twice (rs and rt).
- Decode and the pipeline register live in the top module.

## Test plan
- Reset, then `add r3,r1,r2` with rs = 5, rt = 7 → next cycle `alu_control` = 000, `alu_in1` = 5, `alu_in2` = 7, `ex_rd` = 3, `ex_reg_write` = 1.
- MEM writes r1 = 0x0010 while WB writes r1 = 0x0020, EX holds `sub r4,r1,r1` → `alu_in1` = `alu_in2` = 0x0010.
- `lw r2,0(r1)` followed by `add r5,r2,r2` → `id_stall` = 1 for one cycle, one bubble, then the add issues with r2 forwarded from WB.
- `lui r6,0xAB` → `alu_control` = 110, `alu_in1` = 0, `alu_in2` = 0x00AB.
- `flush` asserted together with a load-use stall → `id_stall` = 0, `ex_valid` = 0 next cycle. Opcode 1111 → `ex_illegal` = 1, `ex_reg_write` = 0.
- `rst` pulsed while EX holds a valid SW → every output is 0 next cycle.
